// File: rtl/vram_write_scheduler_m.sv
// Gates every VRAM write into the window where the GPU reports VRAM writable.
// Two write sources share the single VRAM port:
//   - a CPU write FIFO (addr/data pairs, pushed from the bus decode)
//   - a memset-style fill engine (start address, byte count, fill value)
// When both sources have work, they alternate grants. Reset is synchronous, active-low.
//
// Fill engine states:
//   state     | meaning
//   ----------+----------------------------------------------------------
//   FILL_IDLE | no fill active; fill_start latches a new job
//   FILL_RUN  | fill pending; each granted write advances addr, counts down
module vram_write_scheduler_m #(
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          writable,
  input  logic                          cpu_wr_valid,
  input  logic [ADDR_W-1:0]             cpu_wr_addr,
  input  logic [7:0]                    cpu_wr_data,
  output logic                          cpu_wr_ready,
  input  logic                          fill_start,
  input  logic [ADDR_W-1:0]             fill_addr,
  input  logic [ADDR_W:0]               fill_len,
  input  logic [7:0]                    fill_value,
  output logic                          fill_busy,
  output logic                          fill_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic                          vram_we,
  output logic [ADDR_W-1:0]             vram_addr,
  output logic [7:0]                    vram_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + 8;

  typedef enum logic {FILL_IDLE, FILL_RUN} fill_state_e;

  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]  mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;

  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic [7:0]        fval_q, fval_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              done_q, done_d;

  // 1 = fill engine got the most recent grant; reset to 1 so the CPU wins first contention
  logic              last_fill_q, last_fill_d;

  logic              full, push, cpu_pend, fill_pend, grant_cpu, grant_fill;
  logic [ENT_W-1:0]  head;

  assign full         = (count_q == CNT_W'(FIFO_DEPTH));
  assign cpu_wr_ready = ~full;
  assign push         = cpu_wr_valid & ~full;
  assign cpu_pend     = (count_q != '0);
  assign fill_pend    = (state_q == FILL_RUN);
  assign head         = mem_q[rd_ptr_q];

  assign fifo_count   = count_q;
  assign overflow     = overflow_q;
  assign fill_busy    = fill_pend;
  assign fill_done    = done_q;

  // Arbitration: only while writable; alternate when both sources are pending
  always_comb begin
    grant_cpu  = writable & cpu_pend & (~fill_pend | last_fill_q);
    grant_fill = writable & fill_pend & (~cpu_pend | ~last_fill_q);
    vram_we    = grant_cpu | grant_fill;
    if (grant_fill) begin
      vram_addr = faddr_q;
      vram_data = fval_q;
    end else begin
      vram_addr = head[ENT_W-1:8];
      vram_data = head[7:0];
    end
    last_fill_d = last_fill_q;
    if (grant_cpu) begin
      last_fill_d = 1'b0;
    end else if (grant_fill) begin
      last_fill_d = 1'b1;
    end
  end

  // CPU write FIFO: push on accept, pop on CPU grant, sticky overflow on dropped writes
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) begin
      mem_d[wr_ptr_q] = {cpu_wr_addr, cpu_wr_data};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (grant_cpu) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !grant_cpu) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && grant_cpu) begin
      count_d = count_q - CNT_W'(1);
    end
    if (cpu_wr_valid && full) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end
  end

  // Fill engine next state: latch job in IDLE, count down remaining bytes on each grant
  always_comb begin
    state_d = state_q;
    faddr_d = faddr_q;
    fval_d  = fval_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      FILL_IDLE: begin
        if (fill_start) begin
          faddr_d = fill_addr;
          fval_d  = fill_value;
          rem_d   = fill_len;
          if (fill_len != '0) begin
            state_d = FILL_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FILL_RUN: begin
        if (grant_fill) begin
          faddr_d = faddr_q + ADDR_W'(1);
          rem_d   = rem_q - (ADDR_W+1)'(1);
          if (rem_q == (ADDR_W+1)'(1)) begin
            state_d = FILL_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = FILL_IDLE;
    endcase
  end

  // Register update; FIFO storage is not reset since the count gates every read
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      state_q     <= FILL_IDLE;
      faddr_q     <= '0;
      fval_q      <= '0;
      rem_q       <= '0;
      done_q      <= 1'b0;
      last_fill_q <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      faddr_q     <= faddr_d;
      fval_q      <= fval_d;
      rem_q       <= rem_d;
      done_q      <= done_d;
      last_fill_q <= last_fill_d;
    end
  end

endmodule

// File: tb/tb_vram_write_scheduler_m.sv
// Bench for vram_write_scheduler_m: directed scenarios followed by random traffic.
// A negedge monitor checks every cycle against a queue-based reference model.
module tb_vram_write_scheduler_m;

  localparam int AW = 12;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, writable, cpu_wr_valid, cpu_wr_ready;
  logic [AW-1:0] cpu_wr_addr, fill_addr, vram_addr;
  logic [7:0]    cpu_wr_data, fill_value, vram_data;
  logic          fill_start, fill_busy, fill_done, overflow, overflow_clr, vram_we;
  logic [AW:0]   fill_len;
  logic [4:0]    fifo_count;

  vram_write_scheduler_m #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .writable(writable),
    .cpu_wr_valid(cpu_wr_valid), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
    .cpu_wr_ready(cpu_wr_ready),
    .fill_start(fill_start), .fill_addr(fill_addr), .fill_len(fill_len), .fill_value(fill_value),
    .fill_busy(fill_busy), .fill_done(fill_done), .fifo_count(fifo_count),
    .overflow(overflow), .overflow_clr(overflow_clr),
    .vram_we(vram_we), .vram_addr(vram_addr), .vram_data(vram_data)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: CPU writes as a plain queue, fill job as start address plus remaining count
  logic [19:0]   exp_q[$];
  bit            m_ok = 0;
  bit            m_run, m_last_fill, m_ovf, m_done;
  logic [AW-1:0] m_faddr;
  logic [7:0]    m_fval;
  int            m_rem;

  always @(negedge clk) begin
    bit cpu_p, g_cpu, g_fill, was_run, nd;
    int sz;
    sz = exp_q.size();
    cpu_p = (sz > 0);
    g_cpu  = writable && cpu_p && (!m_run || m_last_fill);
    g_fill = writable && m_run && (!cpu_p || !m_last_fill);
    if (m_ok) begin
      chk("fifo_count", fifo_count, sz);
      chk("cpu_wr_ready", cpu_wr_ready, sz != DEPTH);
      chk("overflow", overflow, m_ovf);
      chk("fill_busy", fill_busy, m_run);
      chk("fill_done", fill_done, m_done);
      chk("vram_we", vram_we, g_cpu || g_fill);
      if (vram_we && g_cpu)  chk("cpu_write", {vram_addr, vram_data}, exp_q[0]);
      if (vram_we && g_fill) chk("fill_write", {vram_addr, vram_data}, {m_faddr, m_fval});
    end
    if (!rst) begin
      exp_q.delete();
      m_run = 0; m_last_fill = 1; m_ovf = 0; m_done = 0; m_rem = 0;
      m_ok = 1;
    end else if (m_ok) begin
      was_run = m_run;
      nd = 0;
      if (g_cpu) begin
        void'(exp_q.pop_front());
        m_last_fill = 0;
      end
      if (g_fill) begin
        m_faddr = m_faddr + 1'b1;
        m_rem = m_rem - 1;
        m_last_fill = 1;
        if (m_rem == 0) begin m_run = 0; nd = 1; end
      end
      if (cpu_wr_valid) begin
        if (sz != DEPTH) exp_q.push_back({cpu_wr_addr, cpu_wr_data});
        else m_ovf = 1;
      end
      if (overflow_clr && !(cpu_wr_valid && sz == DEPTH)) m_ovf = 0;
      if (fill_start && !was_run) begin
        m_faddr = fill_addr;
        m_fval = fill_value;
        m_rem = int'(fill_len);
        if (fill_len != 0) m_run = 1;
        else nd = 1;
      end
      m_done = nd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [7:0] d);
    cpu_wr_valid = 1; cpu_wr_addr = a; cpu_wr_data = d;
    tick();
    cpu_wr_valid = 0;
  endtask

  task automatic start_fill(input logic [AW-1:0] a, input int len, input logic [7:0] v);
    fill_start = 1; fill_addr = a; fill_len = (AW+1)'(len); fill_value = v;
    tick();
    fill_start = 0;
  endtask

  // Bounded wait for both sources to go idle with writable held high
  task automatic drain();
    int k;
    writable = 1;
    k = 0;
    while ((fifo_count != 0 || fill_busy || fill_done) && k < 300) begin
      tick();
      k++;
    end
    chk("drain_timeout", k < 300, 1);
  endtask

  // Counts cycles with vram_we high over a window
  task automatic count_we(input int cycles, output int wc);
    wc = 0;
    for (int i = 0; i < cycles; i++) begin
      #1;
      if (vram_we) wc++;
      tick();
    end
  endtask

  initial begin
    int wc;
    rst = 0; writable = 0; cpu_wr_valid = 1; cpu_wr_addr = '0; cpu_wr_data = '0;
    fill_start = 0; fill_addr = '0; fill_len = '0; fill_value = '0; overflow_clr = 0;

    // reset held with a write request asserted
    tick(); tick();
    chk("rst_count", fifo_count, 0);
    chk("rst_we", vram_we, 0);
    chk("rst_ready", cpu_wr_ready, 1);
    chk("rst_ovf", overflow, 0);
    rst = 1; cpu_wr_valid = 0;
    tick();

    // blanking hold-off
    push(12'h010, 8'hAA); push(12'h011, 8'hBB); push(12'h012, 8'hCC);
    chk("blank_held", fifo_count, 3);
    writable = 1;
    count_we(6, wc);
    chk("blank_we_cycles", wc, 3);
    chk("blank_empty", fifo_count, 0);

    // overflow
    writable = 0;
    for (int i = 0; i < DEPTH + 1; i++) push(AW'(12'h100 + i), 8'(i));
    chk("ovf_ready", cpu_wr_ready, 0);
    chk("ovf_count", fifo_count, DEPTH);
    chk("ovf_set", overflow, 1);
    overflow_clr = 1; tick(); overflow_clr = 0;
    chk("ovf_clr", overflow, 0);
    drain();

    // fill with address wrap
    writable = 1;
    start_fill(12'hFFE, 4, 8'h5A);
    count_we(6, wc);
    chk("wrap_we_cycles", wc, 4);

    // contention with a writable gap in the middle
    writable = 0;
    push(12'h100, 8'h01); push(12'h101, 8'h02); push(12'h102, 8'h03);
    start_fill(12'h200, 3, 8'hF0);
    writable = 1; tick(); tick(); tick();
    writable = 0; tick(); tick(); tick();
    drain();

    // zero-length fill
    writable = 1;
    start_fill(12'h055, 0, 8'h77);
    chk("zero_done", fill_done, 1);
    chk("zero_we", vram_we, 0);
    tick();
    chk("zero_done_pulse", fill_done, 0);

    // restart while busy is ignored
    writable = 0;
    start_fill(12'h300, 3, 8'h11);
    start_fill(12'h400, 7, 8'h22);
    writable = 1;
    count_we(10, wc);
    chk("busy_restart_we", wc, 3);

    // reset in the middle of traffic
    push(12'h500, 8'h01); push(12'h501, 8'h02);
    start_fill(12'h600, 5, 8'h33);
    rst = 0; tick(); rst = 1;
    chk("midrst_count", fifo_count, 0);
    chk("midrst_busy", fill_busy, 0);
    tick();
    chk("midrst_nodone", fill_done, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      writable     = ($urandom_range(0, 3) != 0);
      cpu_wr_valid = $urandom_range(0, 1);
      cpu_wr_addr  = AW'($urandom);
      cpu_wr_data  = 8'($urandom);
      fill_start   = ($urandom_range(0, 19) == 0);
      fill_addr    = AW'($urandom);
      fill_len     = (AW+1)'($urandom_range(0, 6));
      fill_value   = 8'($urandom);
      overflow_clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    cpu_wr_valid = 0; fill_start = 0; overflow_clr = 0;
    drain();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vram_write_scheduler_m.md
# vram_write_scheduler_m

Schedules all writes into GPU VRAM so they only land while the GPU reports VRAM as writable. It sits between the CPU bus decode and the `gpu_m` VRAM write port (`data_in`/`address`/`write_enable` with `SELECT_vram` tied high). It buffers CPU writes in a FIFO and runs a hardware fill (memset) engine. It arbitrates between the two sources, alternating when both have work.

## Interface
Parameters:
- `ADDR_W`, default 12: VRAM address width; must equal `` `VRAM_ADDR_WIDTH ``.
- `FIFO_DEPTH`, default 16: CPU write FIFO entries; must be a power of two, ≥2.

Ports:
- `clk`  in  1  GPU pixel clock (12.5875 MHz).
- `rst`  in  1  Reset, synchronous, active-low: state clears on a rising `clk` edge while `rst`=0.
- `writable`  in  1  From `video_timing_m`; 1 = VRAM may be written this cycle.
- `cpu_wr_valid`  in  1  CPU write request.
- `cpu_wr_addr`  in  ADDR_W  CPU write address.
- `cpu_wr_data`  in  8  CPU write data.
- `cpu_wr_ready`  out  1  FIFO not full.
- `fill_start`  in  1  One-cycle pulse that starts a fill.
- `fill_addr`  in  ADDR_W  Fill start address.
- `fill_len`  in  ADDR_W+1  Number of bytes to write; range 0..2^ADDR_W.
- `fill_value`  in  8  Fill byte.
- `fill_busy`  out  1  Fill in progress.
- `fill_done`  out  1  One-cycle pulse when a fill completes.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  Current FIFO occupancy.
- `overflow`  out  1  Sticky flag: a CPU write was dropped.
- `overflow_clr`  in  1  Clears `overflow`.
- `vram_we`  out  1  To `gpu_m` `write_enable`.
- `vram_addr`  out  ADDR_W  To `gpu_m` `address`.
- `vram_data`  out  8  To `gpu_m` `data_in`.

## Operation
- **FIFO push:** `cpu_wr_valid && cpu_wr_ready` pushes {addr,data}. `cpu_wr_ready` = (`fifo_count` != FIFO_DEPTH). It is derived only from registers and does not account for a same-cycle pop.
- **Overflow:** `cpu_wr_valid` while full drops the write and sets `overflow`. `overflow_clr` clears it. If set and clear happen in the same cycle, set wins.
- **Fill start:** the fill engine has states IDLE and RUN.
  - `fill_start` in IDLE latches addr/value and remaining = `fill_len`.
  - If `fill_len` != 0, the engine goes to RUN.
  - If `fill_len` = 0, the engine stays IDLE and pulses `fill_done` the next cycle.
  - `fill_start` in RUN is ignored.
- **Fill progress:** each granted fill write increments the address (wrapping modulo 2^ADDR_W) and decrements remaining. The grant that takes remaining 1→0 returns the engine to IDLE, and `fill_done` pulses the following cycle.
- **Arbitration:** `cpu_pend` = FIFO non-empty; `fill_pend` = state is RUN.
  - If `writable`=0, nothing is granted.
  - If only one source is pending, it is granted.
  - If both are pending, the source that was not granted last is granted.
  - The `last_grant` register updates only on an actual grant.
- **VRAM outputs:** combinational from registers and `writable`.
  - `vram_we` = `writable` && (`cpu_pend` || `fill_pend`).
  - `vram_addr`/`vram_data` = the FIFO head or the fill registers, per the grant.
  - When there is no grant, `vram_addr`/`vram_data` show the FIFO head; their value is don't-care.
- **Commit:** a grant is committed on that clock edge. A CPU grant pops the FIFO; a fill grant advances the fill engine. Entries are never lost across a `writable` drop.
- **Simultaneous push and pop:** count is unchanged. This is legal even when the FIFO is full, but `cpu_wr_ready`=0 when full, so no push is accepted in that cycle.

## Timing
- Write-to-VRAM latency: a push at edge N makes the entry the head at edge N+1. If `writable`=1 and the CPU is granted, the entry is written in cycle N+1.
- Throughput: one VRAM write per `writable` cycle.
- Reset values: FIFO empty, `fifo_count`=0, `cpu_wr_ready`=1, `overflow`=0, fill IDLE, `fill_busy`=0, `fill_done`=0, `last_grant`=FILL (so the CPU wins the first contention), `vram_we`=0.
- Reset mid-operation abandons the FIFO contents and any fill in progress. `fill_done` is not pulsed for an aborted fill.
- `fill_busy` = (state == RUN). It rises the cycle after the `fill_start` edge.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles with `cpu_wr_valid`=1 → `fifo_count`=0, `vram_we`=0, `cpu_wr_ready`=1, `overflow`=0.
- **Blanking hold-off:** with `writable`=0, push 3 writes (0x010←0xAA, 0x011←0xBB, 0x012←0xCC), then raise `writable` → `vram_we` is 1 for exactly 3 cycles, the writes appear in push order, and `fifo_count` ends at 0.
- **Overflow:** with `writable`=0, push FIFO_DEPTH+1 writes → `cpu_wr_ready`=0 after the 16th, the 17th is dropped, `overflow`=1; `overflow_clr` → `overflow`=0.
- **Fill with wrap:** `fill_addr`=0xFFE, `fill_len`=4, `fill_value`=0x5A, `writable`=1 → writes to 0xFFE, 0xFFF, 0x000, 0x001; `fill_done` pulses 1 cycle after the 4th write; `fill_busy` high for exactly those 4 write cycles.
- **Contention:** fill with `fill_len`=3 running and 3 FIFO entries, `writable`=1 → grant order CPU, FILL, CPU, FILL, CPU, FILL. Dropping `writable` mid-sequence pauses it, and it resumes with no loss.
- **Zero-length and busy restart:** `fill_len`=0 → no `vram_we`, `fill_done` pulses next cycle. A `fill_start` issued during RUN is ignored, so the original fill's address and count are unaffected.
